// File: rtl/pipelined_control_pkg.sv
// Shared encodings for the pipelined control path: opcodes, ALU codes,
// result/immediate selectors and the per-instruction control bundle.
package pipelined_control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
        logic [2:0] funct3;
    } ctrl_t;

    // All-zero bundle is the bubble: no writes, no redirect, ALU add, result from ALU.
    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3,
                                                  input logic       alt,
                                                  input logic       is_r);
        logic [3:0] code;
        case (funct3)
            3'b000:  code = (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pipelined_control_if.sv
// Control-path bundle between the datapath and the pipelined control block.
interface pipelined_control_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int ALU_CTRL_W  = 4
);
    logic [INSTR_WIDTH-1:0] instr_d;
    logic                   flush_e;
    logic                   zero_e;
    logic                   lt_e;
    logic                   ltu_e;
    logic [2:0]             imm_src_d;
    logic                   illegal_d;
    logic [ALU_CTRL_W-1:0]  alu_control_e;
    logic                   alu_src_e;
    logic [1:0]             result_src_e;
    logic                   pc_src_e;
    logic                   jalr_e;
    logic                   reg_write_m;
    logic                   mem_write_m;
    logic [1:0]             result_src_m;
    logic                   reg_write_w;
    logic [1:0]             result_src_w;

    modport master (
        output instr_d, flush_e, zero_e, lt_e, ltu_e,
        input  imm_src_d, illegal_d, alu_control_e, alu_src_e, result_src_e,
               pc_src_e, jalr_e, reg_write_m, mem_write_m, result_src_m,
               reg_write_w, result_src_w
    );

    modport slave (
        input  instr_d, flush_e, zero_e, lt_e, ltu_e,
        output imm_src_d, illegal_d, alu_control_e, alu_src_e, result_src_e,
               pc_src_e, jalr_e, reg_write_m, mem_write_m, result_src_m,
               reg_write_w, result_src_w
    );
endinterface

// File: rtl/pipelined_control_decode.sv
// Combinational instruction decode: RV32 opcode/funct fields to a control bundle.
module pipelined_control_decode
    import pipelined_control_pkg::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output ctrl_t                  ctrl,
    output logic [2:0]             imm_src,
    output logic                   illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];
    assign unused_instr = ^{instr[INSTR_WIDTH-1:31], instr[29:15], instr[11:7]};

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        imm_src = IMM_I;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct(funct3, alt, 1'b1);
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct(funct3, alt, 1'b0);
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            OP_BRANCH: begin
                // funct3 travels with the branch so EX can pick the condition.
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.funct3   = funct3;
                imm_src       = IMM_B;
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control.sv
// Three-stage control pipeline (D->E, E->M, M->W) with EX-stage branch
// resolution; a redirect or external flush turns the next EX slot into a bubble.
module pipelined_control
    import pipelined_control_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_control_if.slave bus
);

    ctrl_t      dec_ctrl;
    ctrl_t      ctrl_p0;
    logic       reg_write_p1;
    logic       mem_write_p1;
    logic [1:0] result_src_p1;
    logic       reg_write_p2;
    logic [1:0] result_src_p2;
    logic       cond_e;
    logic       pc_src;

    pipelined_control_decode #(
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_decode (
        .instr   (bus.instr_d),
        .ctrl    (dec_ctrl),
        .imm_src (bus.imm_src_d),
        .illegal (bus.illegal_d)
    );

    always_comb begin
        case (ctrl_p0.funct3)
            3'b000:  cond_e = bus.zero_e;
            3'b001:  cond_e = ~bus.zero_e;
            3'b100:  cond_e = bus.lt_e;
            3'b101:  cond_e = ~bus.lt_e;
            3'b110:  cond_e = bus.ltu_e;
            3'b111:  cond_e = ~bus.ltu_e;
            default: cond_e = 1'b0;
        endcase
    end

    assign pc_src = ctrl_p0.jump | (ctrl_p0.branch & cond_e);

    // D -> E: the only stage that can take a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_p0 <= CTRL_BUBBLE;
        end else if (pc_src || bus.flush_e) begin
            ctrl_p0 <= CTRL_BUBBLE;
        end else begin
            ctrl_p0 <= dec_ctrl;
        end
    end

    // E -> M and M -> W: always drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            result_src_p1 <= RES_ALU;
            reg_write_p2  <= 1'b0;
            result_src_p2 <= RES_ALU;
        end else begin
            reg_write_p1  <= ctrl_p0.reg_write;
            mem_write_p1  <= ctrl_p0.mem_write;
            result_src_p1 <= ctrl_p0.result_src;
            reg_write_p2  <= reg_write_p1;
            result_src_p2 <= result_src_p1;
        end
    end

    assign bus.alu_control_e = ALU_CTRL_W'(ctrl_p0.alu_ctrl);
    assign bus.alu_src_e     = ctrl_p0.alu_src;
    assign bus.result_src_e  = ctrl_p0.result_src;
    assign bus.pc_src_e      = pc_src;
    assign bus.jalr_e        = ctrl_p0.jalr;
    assign bus.reg_write_m   = reg_write_p1;
    assign bus.mem_write_m   = mem_write_p1;
    assign bus.result_src_m  = result_src_p1;
    assign bus.reg_write_w   = reg_write_p2;
    assign bus.result_src_w  = result_src_p2;

endmodule
